// File: rtl/contador_pkg.sv
// contador_pkg: shared FSM states, direction encodings and default sizes for contador_arbitro.
package contador_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;
endpackage

// File: rtl/contador_arbitro_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, wrapping at N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] win,
  output logic          any_valid
);
  always_comb begin
    int k;
    logic found;
    win = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      k = k >= N ? k - N : k;
      if (!found && req[k[IW-1:0]]) begin
        win = k[IW-1:0];
        found = 1'b1;
      end
    end
    any_valid = |req;
  end
endmodule

// File: rtl/contador_arbitro.sv
// contador_arbitro: round-robin arbiter that turns per-requester up/down requests into
// single-cycle acrescer/decrecer pulses for a shared counter, refusing moves past the limits.
module contador_arbitro
  import contador_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] LIMIT_MAX = '1,
  parameter logic [WIDTH-1:0] LIMIT_MIN = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_dir,
  output logic [N_REQ-1:0]           req_ack,
  output logic                       req_rej,
  input  logic [WIDTH-1:0]           valor,
  output logic                       acrescer,
  output logic                       decrecer,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);
  localparam int IW = $clog2(N_REQ);
  state_t state;
  logic [IW-1:0] ptr, win;
  logic dir, any_valid, issue, limit;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req(req_valid),
    .ptr(ptr),
    .win(win),
    .any_valid(any_valid)
  );

  // limit uses the live valor so a value that settled during SETTLE is honoured
  assign limit = dir ? valor >= LIMIT_MAX : valor <= LIMIT_MIN;
  assign issue = rst_n && state == ISSUE;
  assign req_ack = issue ? N_REQ'(1) << grant_id : '0;
  assign req_rej = issue && limit;
  assign acrescer = issue && dir == DIR_UP && !limit;
  assign decrecer = issue && dir == DIR_DOWN && !limit;
  assign busy = state != IDLE;

  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      grant_id <= '0;
      dir <= 1'b0;
    end else if (state == IDLE) begin
      if (any_valid) begin
        state <= ISSUE;
        grant_id <= win;
        dir <= req_dir[win];
      end
    end else if (state == ISSUE) begin
      state <= limit ? IDLE : SETTLE;
      ptr <= grant_id == IW'(N_REQ - 1) ? '0 : grant_id + 1'b1;
    end else
      state <= IDLE;
endmodule

// File: tb/tb_contador_arbitro.sv
// tb_contador_arbitro: directed checks of contador_arbitro driving a behavioural counter,
// limits narrowed to 8'h6A..8'h6B so both refusal paths are reachable from the reset value.
module tb_contador_arbitro;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid, req_dir, req_ack;
  logic req_rej, acrescer, decrecer, busy;
  logic [7:0] valor;
  logic [1:0] grant_id;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  contador_arbitro #(.N_REQ(4), .WIDTH(8), .LIMIT_MAX(8'h6B), .LIMIT_MIN(8'h6A)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_dir(req_dir),
    .req_ack(req_ack),
    .req_rej(req_rej),
    .valor(valor),
    .acrescer(acrescer),
    .decrecer(decrecer),
    .busy(busy),
    .grant_id(grant_id)
  );

  always_ff @(posedge clk)
    if (!rst_n) valor <= 8'h6A;
    else if (acrescer) valor <= valor + 8'h01;
    else if (decrecer) valor <= valor - 8'h01;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_dir = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_dir = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      cyc();
      n_checks++;
      if ({acrescer, decrecer, req_rej, req_ack} !== 7'b0) begin n_fail++; $display("FAIL reset_pulses: got %b exp 0000000", {acrescer, decrecer, req_rej, req_ack}); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
      n_checks++;
      if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d exp 0", grant_id); end
    end
    req_valid = '0;
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if (valor !== 8'h6A) begin n_fail++; $display("FAIL reset_valor: got %h exp 6a", valor); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b exp 0", busy); end
  endtask

  task automatic test_single_up();
    do_reset();
    req_valid = 4'b0001;
    req_dir = 4'b0001;
    cyc();
    n_checks++;
    if ({acrescer, decrecer, req_rej, req_ack} !== 7'b1000001) begin n_fail++; $display("FAIL up_issue: got %b exp 1000001", {acrescer, decrecer, req_rej, req_ack}); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL up_busy1: got %b exp 1", busy); end
    req_valid = '0;
    cyc();
    n_checks++;
    if (valor !== 8'h6B) begin n_fail++; $display("FAIL up_valor: got %h exp 6b", valor); end
    n_checks++;
    if ({acrescer, busy} !== 2'b01) begin n_fail++; $display("FAIL up_settle: got acrescer/busy %b exp 01", {acrescer, busy}); end
    cyc();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL up_done: got %b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_val [5] = '{8'h6B, 8'h6A, 8'h6B, 8'h6A, 8'h6B};
    int exp_g [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_valid = 4'b1111;
    req_dir = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      cyc();
      n_checks++;
      if (grant_id !== 2'(exp_g[k]) || req_ack !== 4'(1 << exp_g[k])) begin n_fail++; $display("FAIL rr_grant%0d: got id %0d ack %b exp id %0d", k, grant_id, req_ack, exp_g[k]); end
      cyc();
      n_checks++;
      if (valor !== exp_val[k]) begin n_fail++; $display("FAIL rr_valor%0d: got %h exp %h", k, valor, exp_val[k]); end
      cyc();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle%0d: got %b exp 0", k, busy); end
    end
    req_valid = '0;
  endtask

  task automatic test_limit_max();
    do_reset();
    req_valid = 4'b0001;
    req_dir = 4'b0001;
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    req_valid = 4'b0001;
    cyc();
    n_checks++;
    if ({acrescer, decrecer, req_rej, req_ack} !== 7'b0010001) begin n_fail++; $display("FAIL max_issue: got %b exp 0010001", {acrescer, decrecer, req_rej, req_ack}); end
    req_valid = '0;
    cyc();
    n_checks++;
    if (busy !== 1'b0 || valor !== 8'h6B) begin n_fail++; $display("FAIL max_after: got busy %b valor %h exp 0 6b", busy, valor); end
  endtask

  task automatic test_limit_min();
    do_reset();
    req_valid = 4'b1000;
    req_dir = 4'b0000;
    cyc();
    n_checks++;
    if ({acrescer, decrecer, req_rej, req_ack} !== 7'b0011000) begin n_fail++; $display("FAIL min_issue: got %b exp 0011000", {acrescer, decrecer, req_rej, req_ack}); end
    req_valid = '0;
    cyc();
    n_checks++;
    if (busy !== 1'b0 || valor !== 8'h6A) begin n_fail++; $display("FAIL min_after: got busy %b valor %h exp 0 6a", busy, valor); end
  endtask

  task automatic test_pointer();
    do_reset();
    req_valid = 4'b0010;
    req_dir = 4'b0000;
    cyc();
    req_valid = '0;
    cyc();
    req_valid = 4'b0110;
    req_dir = 4'b0100;
    cyc();
    n_checks++;
    if (grant_id !== 2'd2 || acrescer !== 1'b1) begin n_fail++; $display("FAIL ptr_first: got id %0d acrescer %b exp 2 1", grant_id, acrescer); end
    req_valid = 4'b0010;
    cyc();
    n_checks++;
    if (valor !== 8'h6B) begin n_fail++; $display("FAIL ptr_valor1: got %h exp 6b", valor); end
    cyc();
    cyc();
    n_checks++;
    if (grant_id !== 2'd1 || decrecer !== 1'b1) begin n_fail++; $display("FAIL ptr_second: got id %0d decrecer %b exp 1 1", grant_id, decrecer); end
    req_valid = '0;
    cyc();
    n_checks++;
    if (valor !== 8'h6A) begin n_fail++; $display("FAIL ptr_valor2: got %h exp 6a", valor); end
    cyc();
  endtask

  task automatic test_reset_in_issue();
    do_reset();
    req_valid = 4'b0010;
    req_dir = 4'b0010;
    cyc();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({acrescer, decrecer, req_rej, req_ack} !== 7'b0) begin n_fail++; $display("FAIL rst_issue_gate: got %b exp 0000000", {acrescer, decrecer, req_rej, req_ack}); end
    cyc();
    n_checks++;
    if (busy !== 1'b0 || grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_issue_idle: got busy %b id %0d exp 0 0", busy, grant_id); end
    rst_n = 1'b1;
    req_valid = 4'b0011;
    req_dir = 4'b0011;
    cyc();
    n_checks++;
    if (grant_id !== 2'd0 || req_ack !== 4'b0001) begin n_fail++; $display("FAIL rst_issue_ptr: got id %0d ack %b exp 0 0001", grant_id, req_ack); end
    req_valid = '0;
    cyc();
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_round_robin();
    test_limit_max();
    test_limit_min();
    test_pointer();
    test_reset_in_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/contador_arbitro.md
Name: contador_arbitro

Overview:
- Shares one up/down counter (8-bit, reset value 8'h6A, inputs acrescer/decrecer) among N_REQ requesters.
- Each requester asks for one increment or decrement. The block picks a winner round-robin, checks the winner's request against configurable limits, then issues exactly one single-cycle acrescer or decrecer pulse.
- Sits between the requesting logic and the counter. The counter's output is fed back to the `valor` input.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, counter width
- LIMIT_MAX, 8'hFF, an up request is refused when valor >= LIMIT_MAX
- LIMIT_MIN, 8'h00, a down request is refused when valor <= LIMIT_MIN

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  N_REQ  per-requester request; held high until acked
- req_dir  in  N_REQ  per-requester direction: 1 = up, 0 = down
- req_ack  out  N_REQ  one-hot, one-cycle acknowledge to the winner
- req_rej  out  1  high with req_ack when the request was refused at a limit
- valor  in  WIDTH  current counter value (counter saida)
- acrescer  out  1  increment pulse to the counter
- decrecer  out  1  decrement pulse to the counter
- busy  out  1  high while state != IDLE
- grant_id  out  $clog2(N_REQ)  index of the current or last winner

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE, rr pointer=0, grant_id=0, latched dir=0.
  - acrescer, decrecer, req_ack, req_rej are gated with rst_n, so they are 0 in any cycle where rst_n=0.
- FSM states: IDLE, ISSUE, SETTLE.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from the rr pointer upward, wrapping at N_REQ.
  - Latch the winner into grant_id and its req_dir into dir; next state is ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE (exactly one cycle):
  - limit = (dir && valor >= LIMIT_MAX) || (!dir && valor <= LIMIT_MIN), evaluated combinationally on the current valor.
  - req_ack[grant_id]=1 and req_rej=limit.
  - acrescer = dir && !limit; decrecer = !dir && !limit.
  - rr pointer <= grant_id+1, wrapping modulo N_REQ.
  - Next state: IDLE if limit, else SETTLE.
- SETTLE (exactly one cycle):
  - No outputs asserted; the counter updates on the ISSUE edge and valor settles here.
  - Next state: IDLE.
- Latency: request sampled in IDLE at cycle t → ack/pulse in cycle t+1 → IDLE again at t+3, or at t+2 if rejected.
- Throughput: sustained one operation per 3 cycles.
- acrescer and decrecer are never high together and never high for more than 1 consecutive cycle.
- If req_valid drops after being latched, the latched operation still completes.
- A requester that keeps req_valid high after its ack is treated as a new request.
- Wrap-around: there is no wrap check beyond the limits. With the default limits the counter never wraps past 8'hFF/8'h00.
- Reset during ISSUE: pulses are suppressed in that cycle, the FSM is in IDLE on the next cycle, and the pointer is 0.

Decomposition:
- Package contador_pkg holds:
  - state enum {IDLE, ISSUE, SETTLE}
  - constants DIR_UP=1'b1, DIR_DOWN=1'b0
  - default WIDTH/N_REQ
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req vector and pointer.
  - Outputs: winner index and any_valid.
  - Instantiated once inside contador_arbitro.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with all req_valid=1 → acrescer=decrecer=0, req_ack=0, busy=0, grant_id=0 throughout. After release, the counter still reads 8'h6A.
2. Single up request: req_valid=4'b0001, req_dir=1, valor=8'h6A.
   - Next cycle: acrescer=1 for 1 cycle, req_ack=4'b0001, req_rej=0.
   - Counter reads 8'h6B in SETTLE; busy is high for 2 cycles.
3. All four valid continuously, mixed dir=4'b0101, start 8'h6A.
   - Grants occur in order 0,1,2,3,0, one every 3 cycles.
   - Counter sequence: 6B,6A,6B,6A,6B.
4. Limit hit: LIMIT_MAX=8'h6B, valor=8'h6B, up request → req_ack and req_rej=1, no acrescer pulse, FSM back in IDLE 2 cycles after sampling.
5. Down request at LIMIT_MIN=8'h6A, valor=8'h6A → req_rej=1, decrecer stays 0.
6. Round-robin pointer at 2, req_valid=4'b0110 (req1 down, req2 up) → req2 served first (counter 6B), then req1 (counter 6A).
7. Reset asserted during the ISSUE cycle → no pulse that cycle, IDLE and pointer 0 on the next cycle.
